// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver: pin conditioning, 11-bit deframing, Set-2 event decode
module ps2_scancode_rx #(
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       new_key,
    output logic       key_released,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       frame_err
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_clk_f, r_clk_f_d;
    logic [7:0]      r_flt_cnt;
    state_t          r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext, r_brk;
    logic [7:0]      r_held;
    logic            r_held_ext, r_held_vld;

    logic            w_fall;
    logic            w_frame_ok;
    logic            w_is_held;
    logic            w_timeout;

    // Filtered clock follows the synchronized pin only after FILTER_LEN disagreeing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2_data;
            r_dat_s2  <= r_dat_s1;
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == 8'(FILTER_LEN - 1)) begin
                r_clk_f   <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 8'd1;
            end
        end
    end

    assign w_fall     = r_clk_f_d & ~r_clk_f;
    assign w_frame_ok = r_dat_s2 & (^{r_shift, r_par});
    assign w_is_held  = r_held_vld && (r_held == r_shift) && (r_held_ext == r_ext);
    assign w_timeout  = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_to_cnt     <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_held       <= '0;
            r_held_ext   <= 1'b0;
            r_held_vld   <= 1'b0;
            new_key      <= 1'b0;
            key_released <= 1'b0;
            key_code     <= '0;
            key_extended <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            new_key      <= 1'b0;
            key_released <= 1'b0;
            frame_err    <= 1'b0;

            if (w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        if (!r_dat_s2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_fall) begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_fall) begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                        if (!w_frame_ok) begin
                            frame_err <= 1'b1;
                            r_ext     <= 1'b0;
                            r_brk     <= 1'b0;
                        end else if (r_shift == 8'hE0) begin
                            r_ext <= 1'b1;
                        end else if (r_shift == 8'hF0) begin
                            r_brk <= 1'b1;
                        end else if (!r_ext && !r_brk && (r_shift == 8'hAA || r_shift == 8'hFA)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_ext <= 1'b0;
                            r_brk <= 1'b0;
                            if (r_brk) begin
                                key_released <= 1'b1;
                                key_code     <= r_shift;
                                key_extended <= r_ext;
                                if (w_is_held) begin
                                    r_held_vld <= 1'b0;
                                end
                            end else if (!(SUPPRESS_REPEAT && w_is_held)) begin
                                new_key      <= 1'b1;
                                key_code     <= r_shift;
                                key_extended <= r_ext;
                                r_held       <= r_shift;
                                r_held_ext   <= r_ext;
                                r_held_vld   <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A stalled frame is abandoned along with any half-received prefix sequence.
            if (w_timeout) begin
                r_state   <= S_IDLE;
                frame_err <= 1'b1;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
            end
        end
    end
endmodule
